matrix_row_read_unit: RTL and testbench

Reads all N_ROWS rows of one matrix register, in order, through a register-file read port. Streams each row to a downstream consumer (store/move datapath) over a valid/ready interface. It is the reader counterpart to the matrix row-write units: it issues instruction-queued row reads, buffers the returned data in a credit-limited output FIFO, and reports completion through the finished/ack handshake with the instruction ID.

---
 rtl/matrix_row_read_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_matrix_row_read_unit.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_read_unit.sv
// Matrix register row reader: queues row-read instructions, issues credit-limited
// register-file row reads and streams the returned rows out over valid/ready.
package xif_pkg;
  localparam int X_ID_WIDTH = 4;
endpackage

module matrix_row_read_unit #(
  parameter int DEPTH     = 1,
  parameter int RLEN      = 128,
  parameter int N_REGS    = 8,
  parameter int N_ROWS    = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [$clog2(N_REGS)-1:0]      operand_reg_i,
  input  logic                           start_i,
  input  logic [xif_pkg::X_ID_WIDTH-1:0] instr_id_i,
  output logic                           busy_o,
  output logic [xif_pkg::X_ID_WIDTH-1:0] id_o,
  output logic [$clog2(N_REGS)-1:0]      raddr_o,
  output logic [$clog2(N_ROWS)-1:0]      rrowaddr_o,
  output logic                           re_o,
  input  logic                           rgnt_i,
  input  logic                           rvalid_i,
  input  logic [RLEN-1:0]                rdata_i,
  output logic [RLEN-1:0]                row_data_o,
  output logic [$clog2(N_ROWS)-1:0]      row_idx_o,
  output logic                           row_last_o,
  output logic                           row_valid_o,
  input  logic                           row_ready_i,
  output logic                           finished_o,
  input  logic                           finished_ack_i,
  output logic [xif_pkg::X_ID_WIDTH-1:0] finished_instr_id_o
);

  localparam int RGW = $clog2(N_REGS);
  localparam int RW  = $clog2(N_ROWS);
  localparam int IDW = xif_pkg::X_ID_WIDTH;
  localparam int QAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QCW = $clog2(DEPTH + 1);
  localparam int OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW  = $clog2(OUT_DEPTH + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);

  if (N_ROWS < 2) begin : g_bad_rows
    $error("matrix_row_read_unit: N_ROWS must be >= 2");
  end
  if (OUT_DEPTH < 1) begin : g_bad_out_depth
    $error("matrix_row_read_unit: OUT_DEPTH must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t           state_reg, state_next;
  logic [RGW-1:0]   cur_reg_reg;
  logic [IDW-1:0]   cur_id_reg;
  logic [RW-1:0]    issue_cnt_reg;
  logic [RW-1:0]    rx_cnt_reg;
  logic [CW-1:0]    outstanding_reg;
  logic             finished_reg;
  logic [IDW-1:0]   fin_id_reg;

  // ---------------- instruction queue ----------------
  logic [RGW-1:0] q_reg_mem [DEPTH];
  logic [IDW-1:0] q_id_mem  [DEPTH];
  logic [QAW-1:0] q_wptr_reg, q_rptr_reg;
  logic [QCW-1:0] q_cnt_reg;
  logic           q_full, q_empty, q_push, q_pop;

  function automatic logic [QAW-1:0] q_inc(input logic [QAW-1:0] p);
    return (p == QAW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign q_full  = (q_cnt_reg == QCW'(DEPTH));
  assign q_empty = (q_cnt_reg == '0);
  assign q_push  = start_i & ~q_full;
  assign busy_o  = q_full | (q_cnt_reg == QCW'(DEPTH - 1));

  always_ff @(posedge clk_i) begin
    if (q_push) begin
      q_reg_mem[q_wptr_reg] <= operand_reg_i;
      q_id_mem[q_wptr_reg]  <= instr_id_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_wptr_reg <= '0;
      q_rptr_reg <= '0;
      q_cnt_reg  <= '0;
    end else begin
      if (q_push) q_wptr_reg <= q_inc(q_wptr_reg);
      if (q_pop)  q_rptr_reg <= q_inc(q_rptr_reg);
      case ({q_push, q_pop})
        2'b10:   q_cnt_reg <= q_cnt_reg + 1'b1;
        2'b01:   q_cnt_reg <= q_cnt_reg - 1'b1;
        default: q_cnt_reg <= q_cnt_reg;
      endcase
    end
  end

  // ---------------- output FIFO ----------------
  logic [OUT_DEPTH-1:0][RLEN-1:0] of_data_reg;
  logic [OUT_DEPTH-1:0][RW-1:0]   of_idx_reg;
  logic [OUT_DEPTH-1:0]           of_last_reg;
  logic [OUT_DEPTH-1:0]           of_we;
  logic [OAW-1:0]                 of_wptr_reg, of_rptr_reg;
  logic [CW-1:0]                  fifo_cnt_reg;
  logic                           fifo_empty, head_last, mask_last, out_fire, last_xfer;

  function automatic logic [OAW-1:0] of_inc(input logic [OAW-1:0] p);
    return (p == OAW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar gi = 0; gi < OUT_DEPTH; gi++) begin : g_of_we
    assign of_we[gi] = rvalid_i && (of_wptr_reg == OAW'(gi));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      of_data_reg <= '0;
      of_idx_reg  <= '0;
      of_last_reg <= '0;
    end else begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        if (of_we[i]) begin
          of_data_reg[i] <= rdata_i;
          of_idx_reg[i]  <= rx_cnt_reg;
          of_last_reg[i] <= (rx_cnt_reg == LAST_ROW);
        end
      end
    end
  end

  assign fifo_empty  = (fifo_cnt_reg == '0);
  assign head_last   = of_last_reg[of_rptr_reg];
  // An unacknowledged finish blocks the next instruction's last row so that
  // finished_instr_id_o is never overwritten before the consumer sees it.
  assign mask_last   = head_last & finished_reg & ~finished_ack_i;
  assign row_valid_o = ~fifo_empty & ~mask_last;
  assign out_fire    = row_valid_o & row_ready_i;
  assign last_xfer   = out_fire & head_last;
  assign row_data_o  = of_data_reg[of_rptr_reg];
  assign row_idx_o   = of_idx_reg[of_rptr_reg];
  assign row_last_o  = head_last;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      of_wptr_reg  <= '0;
      of_rptr_reg  <= '0;
      fifo_cnt_reg <= '0;
      rx_cnt_reg   <= '0;
    end else begin
      if (rvalid_i) begin
        of_wptr_reg <= of_inc(of_wptr_reg);
        rx_cnt_reg  <= (rx_cnt_reg == LAST_ROW) ? '0 : rx_cnt_reg + 1'b1;
      end
      if (out_fire) of_rptr_reg <= of_inc(of_rptr_reg);
      case ({rvalid_i, out_fire})
        2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 1'b1;
        2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 1'b1;
        default: fifo_cnt_reg <= fifo_cnt_reg;
      endcase
    end
  end

  // ---------------- issue FSM ----------------
  logic credit_ok, issue_fire;

  assign credit_ok  = ({1'b0, outstanding_reg} + {1'b0, fifo_cnt_reg}) < (CW+1)'(OUT_DEPTH);
  assign issue_fire = re_o & rgnt_i;

  always_comb begin
    state_next = state_reg;
    q_pop      = 1'b0;
    re_o       = 1'b0;
    raddr_o    = '0;
    rrowaddr_o = '0;
    case (state_reg)
      S_IDLE: begin
        if (!q_empty) begin
          q_pop      = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        re_o       = credit_ok;
        raddr_o    = cur_reg_reg;
        rrowaddr_o = issue_cnt_reg;
        if (issue_fire && (issue_cnt_reg == LAST_ROW)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_xfer) begin
          // Pop straight into the next instruction so ISSUE follows without a bubble.
          if (!q_empty) begin
            q_pop      = 1'b1;
            state_next = S_ISSUE;
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg       <= S_IDLE;
      cur_reg_reg     <= '0;
      cur_id_reg      <= '0;
      issue_cnt_reg   <= '0;
      outstanding_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (q_pop) begin
        cur_reg_reg   <= q_reg_mem[q_rptr_reg];
        cur_id_reg    <= q_id_mem[q_rptr_reg];
        issue_cnt_reg <= '0;
      end else if (issue_fire) begin
        issue_cnt_reg <= (issue_cnt_reg == LAST_ROW) ? '0 : issue_cnt_reg + 1'b1;
      end
      case ({issue_fire, rvalid_i})
        2'b10:   outstanding_reg <= outstanding_reg + 1'b1;
        2'b01:   outstanding_reg <= outstanding_reg - 1'b1;
        default: outstanding_reg <= outstanding_reg;
      endcase
    end
  end

  assign id_o = cur_id_reg;

  // ---------------- completion ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      finished_reg <= 1'b0;
      fin_id_reg   <= '0;
    end else if (last_xfer) begin
      finished_reg <= 1'b1;
      fin_id_reg   <= cur_id_reg;
    end else if (finished_ack_i) begin
      finished_reg <= 1'b0;
      fin_id_reg   <= '0;
    end
  end

  assign finished_o          = finished_reg;
  assign finished_instr_id_o = fin_id_reg;

  a_rvalid_has_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) rvalid_i |-> (outstanding_reg != '0));

  a_fifo_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    rvalid_i |-> ((fifo_cnt_reg != CW'(OUT_DEPTH)) || out_fire));

endmodule

// File: tb/tb_matrix_row_read_unit.sv
// Directed bench for matrix_row_read_unit: single read, backpressure, held finish,
// finish/ack overlap, grant stalls and mid-operation reset.
module tb_matrix_row_read_unit;

  localparam int IDW = xif_pkg::X_ID_WIDTH;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [2:0]     operand_reg_i;
  logic           start_i;
  logic [IDW-1:0] instr_id_i;
  logic           busy_o;
  logic [IDW-1:0] id_o;
  logic [2:0]     raddr_o;
  logic [1:0]     rrowaddr_o;
  logic           re_o;
  logic           rgnt_i;
  logic           rvalid_i;
  logic [127:0]   rdata_i;
  logic [127:0]   row_data_o;
  logic [1:0]     row_idx_o;
  logic           row_last_o;
  logic           row_valid_o;
  logic           row_ready_i;
  logic           finished_o;
  logic           finished_ack_i;
  logic [IDW-1:0] finished_instr_id_o;

  matrix_row_read_unit #(
    .DEPTH(1), .RLEN(128), .N_REGS(8), .N_ROWS(4), .OUT_DEPTH(2)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .operand_reg_i(operand_reg_i), .start_i(start_i),
    .instr_id_i(instr_id_i), .busy_o(busy_o), .id_o(id_o), .raddr_o(raddr_o),
    .rrowaddr_o(rrowaddr_o), .re_o(re_o), .rgnt_i(rgnt_i), .rvalid_i(rvalid_i),
    .rdata_i(rdata_i), .row_data_o(row_data_o), .row_idx_o(row_idx_o),
    .row_last_o(row_last_o), .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
    .finished_o(finished_o), .finished_ack_i(finished_ack_i),
    .finished_instr_id_o(finished_instr_id_o)
  );

  initial forever #5 clk_i = ~clk_i;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   idx;
    logic         last;
    int           cyc;
  } xfer_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         out_model = 0;
  int         out_max   = 0;
  logic [4:0] grant_q[$];
  xfer_t      xfer_q[$];

  function automatic logic [127:0] mkdata(input logic [2:0] r, input logic [1:0] row);
    return {5'd0, r, 6'd0, row, 112'h1234_5678_9ABC_DEF0_1122_3344_5566};
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // Register-file model: every granted read returns one cycle later.
  initial begin
    logic       g;
    logic [2:0] ga;
    logic [1:0] gr;
    rvalid_i = 1'b0;
    rdata_i  = '0;
    forever begin
      @(negedge clk_i);
      g  = re_o && rgnt_i && rst_ni;
      ga = raddr_o;
      gr = rrowaddr_o;
      @(posedge clk_i);
      #1;
      rvalid_i = g && rst_ni;
      rdata_i  = g ? mkdata(ga, gr) : '0;
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (rst_ni) begin
      if (rvalid_i) out_model--;
      if (re_o && rgnt_i) begin
        grant_q.push_back({raddr_o, rrowaddr_o});
        out_model++;
      end
      if (out_model > out_max) out_max = out_model;
      if (row_valid_o && row_ready_i) begin
        xfer_t x;
        x.data = row_data_o;
        x.idx  = row_idx_o;
        x.last = row_last_o;
        x.cyc  = cyc;
        xfer_q.push_back(x);
        $display("row xfer: cycle=%0d idx=%0d last=%0b data=%h", cyc, row_idx_o, row_last_o, row_data_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start(input logic [2:0] r, input logic [IDW-1:0] id);
    operand_reg_i = r;
    instr_id_i    = id;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
  endtask

  task automatic wait_fin(input string name, output int fc);
    int n;
    n  = 0;
    while (finished_o !== 1'b1 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    fc = cyc;
    n_checks++;
    if (finished_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_finish_timeout: finished_o=%b required 1 within 200 cycles", name, finished_o);
    end
  endtask

  task automatic ack_pulse();
    finished_ack_i = 1'b1;
    tick();
    finished_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; operand_reg_i = '0; instr_id_i = '0;
    rgnt_i = 1'b0; row_ready_i = 1'b0; finished_ack_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({re_o, row_valid_o, finished_o, row_last_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: re/valid/fin/last=%b required 0000", {re_o, row_valid_o, finished_o, row_last_o});
    end
    n_checks++;
    if (id_o !== 0 || raddr_o !== 0 || rrowaddr_o !== 0 || row_idx_o !== 0 || finished_instr_id_o !== 0) begin
      n_fail++;
      $display("FAIL reset_fields: id=%0d raddr=%0d row=%0d idx=%0d fid=%0d required all 0",
               id_o, raddr_o, rrowaddr_o, row_idx_o, finished_instr_id_o);
    end
    n_checks++;
    if (row_data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: row_data_o=%h required 0", row_data_o);
    end
    // With a single-entry queue an empty queue is already "almost full".
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy: busy_o=%b required 1", busy_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int fc;
    rgnt_i = 1'b1; row_ready_i = 1'b1; finished_ack_i = 1'b0;
    grant_q.delete(); xfer_q.delete();
    pulse_start(3'd3, 4'd5);
    tick();
    n_checks++;
    if (id_o !== 4'd5 || re_o !== 1'b1 || raddr_o !== 3'd3 || rrowaddr_o !== 2'd0) begin
      n_fail++;
      $display("FAIL single_first_issue: id=%0d re=%b raddr=%0d row=%0d required 5 1 3 0", id_o, re_o, raddr_o, rrowaddr_o);
    end
    wait_fin("single", fc);
    n_checks++;
    if (grant_q.size() != 4 || xfer_q.size() != 4) begin
      n_fail++;
      $display("FAIL single_counts: grants=%0d xfers=%0d required 4 4", grant_q.size(), xfer_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [4:0] eg;
      eg = {3'd3, 2'(i)};
      n_checks++;
      if (grant_q[i] !== eg || xfer_q[i].idx !== 2'(i) || xfer_q[i].last !== (i == 3) ||
          xfer_q[i].data !== mkdata(3'd3, 2'(i))) begin
        n_fail++;
        $display("FAIL single_row%0d: grant=%h idx=%0d last=%b data=%h required grant=%h idx=%0d last=%b data=%h",
                 i, grant_q[i], xfer_q[i].idx, xfer_q[i].last, xfer_q[i].data, eg, i, (i == 3), mkdata(3'd3, 2'(i)));
      end
    end
    n_checks++;
    if (fc != xfer_q[3].cyc + 1 || finished_instr_id_o !== 4'd5) begin
      n_fail++;
      $display("FAIL single_finish: fin_cycle=%0d id=%0d required cycle %0d id 5", fc, finished_instr_id_o, xfer_q[3].cyc + 1);
    end
    tick();
    ack_pulse();
    n_checks++;
    if (finished_o !== 1'b0 || finished_instr_id_o !== 0 || row_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ack_clear: fin=%b id=%0d valid=%b required 0 0 0", finished_o, finished_instr_id_o, row_valid_o);
    end
  endtask

  task automatic test_backpressure();
    int fc;
    rgnt_i = 1'b1; row_ready_i = 1'b0;
    grant_q.delete(); xfer_q.delete();
    pulse_start(3'd2, 4'd6);
    repeat (12) tick();
    n_checks++;
    if (grant_q.size() != 2 || re_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_credit_limit: grants=%0d re=%b required 2 0", grant_q.size(), re_o);
    end
    n_checks++;
    if (row_valid_o !== 1'b1 || row_idx_o !== 2'd0 || row_data_o !== mkdata(3'd2, 2'd0)) begin
      n_fail++;
      $display("FAIL bp_head: valid=%b idx=%0d data=%h required 1 0 %h", row_valid_o, row_idx_o, row_data_o, mkdata(3'd2, 2'd0));
    end
    row_ready_i = 1'b1;
    wait_fin("bp", fc);
    n_checks++;
    if (grant_q.size() != 4 || xfer_q.size() != 4 || finished_instr_id_o !== 4'd6) begin
      n_fail++;
      $display("FAIL bp_counts: grants=%0d xfers=%0d fid=%0d required 4 4 6", grant_q.size(), xfer_q.size(), finished_instr_id_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (grant_q[i] !== {3'd2, 2'(i)} || xfer_q[i].idx !== 2'(i) || xfer_q[i].data !== mkdata(3'd2, 2'(i))) begin
        n_fail++;
        $display("FAIL bp_row%0d: grant=%h idx=%0d data=%h required row %0d data %h",
                 i, grant_q[i], xfer_q[i].idx, xfer_q[i].data, i, mkdata(3'd2, 2'(i)));
      end
    end
    tick();
    ack_pulse();
  endtask

  task automatic test_unacked_finish();
    int fc;
    rgnt_i = 1'b1; row_ready_i = 1'b1; finished_ack_i = 1'b0;
    grant_q.delete(); xfer_q.delete();
    pulse_start(3'd1, 4'd1);
    tick();
    pulse_start(3'd4, 4'd2);
    wait_fin("unacked_first", fc);
    n_checks++;
    if (finished_instr_id_o !== 4'd1) begin
      n_fail++;
      $display("FAIL unacked_first_id: fid=%0d required 1", finished_instr_id_o);
    end
    tick();
    repeat (30) tick();
    n_checks++;
    if (xfer_q.size() != 7 || row_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL unacked_hold: xfers=%0d valid=%b required 7 0", xfer_q.size(), row_valid_o);
    end
    n_checks++;
    if (row_idx_o !== 2'd3 || row_last_o !== 1'b1 || row_data_o !== mkdata(3'd4, 2'd3)) begin
      n_fail++;
      $display("FAIL unacked_head: idx=%0d last=%b data=%h required 3 1 %h", row_idx_o, row_last_o, row_data_o, mkdata(3'd4, 2'd3));
    end
    n_checks++;
    if (finished_o !== 1'b1 || finished_instr_id_o !== 4'd1) begin
      n_fail++;
      $display("FAIL unacked_finish_held: fin=%b fid=%0d required 1 1", finished_o, finished_instr_id_o);
    end
    for (int i = 0; i < 7; i++) begin
      logic [2:0] er;
      er = (i < 4) ? 3'd1 : 3'd4;
      n_checks++;
      if (grant_q[i] !== {er, 2'(i % 4)} || xfer_q[i].data !== mkdata(er, 2'(i % 4)) || xfer_q[i].idx !== 2'(i % 4)) begin
        n_fail++;
        $display("FAIL unacked_row%0d: grant=%h idx=%0d data=%h required reg %0d row %0d",
                 i, grant_q[i], xfer_q[i].idx, xfer_q[i].data, er, i % 4);
      end
    end
  endtask

  task automatic test_finish_ack_same();
    finished_ack_i = 1'b1;
    #1;
    n_checks++;
    if (row_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL same_unmask: row_valid_o=%b required 1 while ack high", row_valid_o);
    end
    @(posedge clk_i);
    #1;
    finished_ack_i = 1'b0;
    n_checks++;
    if (finished_o !== 1'b1 || finished_instr_id_o !== 4'd2) begin
      n_fail++;
      $display("FAIL same_finish_id: fin=%b fid=%0d required 1 2", finished_o, finished_instr_id_o);
    end
    n_checks++;
    if (xfer_q.size() != 8 || xfer_q[7].data !== mkdata(3'd4, 2'd3) || xfer_q[7].last !== 1'b1) begin
      n_fail++;
      $display("FAIL same_last_row: xfers=%0d data=%h last=%b required 8 %h 1",
               xfer_q.size(), xfer_q[7].data, xfer_q[7].last, mkdata(3'd4, 2'd3));
    end
    ack_pulse();
    n_checks++;
    if (finished_o !== 1'b0) begin
      n_fail++;
      $display("FAIL same_final_ack: fin=%b required 0", finished_o);
    end
  endtask

  task automatic test_grant_stall();
    int         fc;
    logic [15:0] pat;
    logic        prev_stall;
    logic [1:0]  prev_row;
    pat = 16'b0110_1001_0011_0100;
    prev_stall = 1'b0; prev_row = '0;
    row_ready_i = 1'b1; finished_ack_i = 1'b0;
    grant_q.delete(); xfer_q.delete(); out_max = 0;
    pulse_start(3'd5, 4'd9);
    for (int i = 0; i < 80 && finished_o !== 1'b1; i++) begin
      rgnt_i = pat[i % 16];
      @(negedge clk_i);
      if (prev_stall) begin
        n_checks++;
        if (re_o !== 1'b1 || rrowaddr_o !== prev_row) begin
          n_fail++;
          $display("FAIL stall_hold: re=%b row=%0d required 1 %0d", re_o, rrowaddr_o, prev_row);
        end
      end
      prev_stall = re_o && !rgnt_i;
      prev_row   = rrowaddr_o;
      @(posedge clk_i);
      #1;
    end
    rgnt_i = 1'b1;
    wait_fin("stall", fc);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (grant_q[i] !== {3'd5, 2'(i)} || xfer_q[i].idx !== 2'(i) || xfer_q[i].data !== mkdata(3'd5, 2'(i))) begin
        n_fail++;
        $display("FAIL stall_row%0d: grant=%h idx=%0d data=%h required row %0d data %h",
                 i, grant_q[i], xfer_q[i].idx, xfer_q[i].data, i, mkdata(3'd5, 2'(i)));
      end
    end
    n_checks++;
    if (out_max > 2 || grant_q.size() != 4 || finished_instr_id_o !== 4'd9) begin
      n_fail++;
      $display("FAIL stall_summary: max_outstanding=%0d grants=%0d fid=%0d required <=2 4 9", out_max, grant_q.size(), finished_instr_id_o);
    end
    tick();
    ack_pulse();
  endtask

  task automatic test_reset_mid();
    int fc;
    rgnt_i = 1'b1; row_ready_i = 1'b1; finished_ack_i = 1'b0;
    grant_q.delete(); xfer_q.delete();
    pulse_start(3'd6, 4'd3);
    tick();
    tick();
    n_checks++;
    if (re_o !== 1'b1 || rrowaddr_o !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_pre_reset: re=%b row=%0d required 1 1", re_o, rrowaddr_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({re_o, row_valid_o, finished_o, row_last_o} !== 4'b0 || id_o !== 0 || raddr_o !== 0 ||
        rrowaddr_o !== 0 || row_data_o !== '0 || row_idx_o !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: re=%b valid=%b fin=%b last=%b id=%0d raddr=%0d row=%0d idx=%0d data=%h required all 0",
               re_o, row_valid_o, finished_o, row_last_o, id_o, raddr_o, rrowaddr_o, row_idx_o, row_data_o);
    end
    repeat (3) @(posedge clk_i);
    #3;
    rst_ni = 1'b1;
    tick();
    grant_q.delete(); xfer_q.delete(); out_model = 0;
    pulse_start(3'd7, 4'd11);
    wait_fin("mid", fc);
    n_checks++;
    if (grant_q.size() != 4 || xfer_q.size() != 4 || finished_instr_id_o !== 4'd11) begin
      n_fail++;
      $display("FAIL mid_after: grants=%0d xfers=%0d fid=%0d required 4 4 11", grant_q.size(), xfer_q.size(), finished_instr_id_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (grant_q[i] !== {3'd7, 2'(i)} || xfer_q[i].idx !== 2'(i) || xfer_q[i].data !== mkdata(3'd7, 2'(i))) begin
        n_fail++;
        $display("FAIL mid_row%0d: grant=%h idx=%0d data=%h required row %0d data %h",
                 i, grant_q[i], xfer_q[i].idx, xfer_q[i].data, i, mkdata(3'd7, 2'(i)));
      end
    end
    tick();
    ack_pulse();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_unacked_finish();
    test_finish_ack_same();
    test_grant_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
